adder_seq_ctrl: RTL and testbench

Multi-cycle sequencer for wide additions over a narrow CHUNK-bit adder datapath.
- Accepts one WIDTH-bit operand pair plus carry-in via a valid/ready handshake.
- Steps the chunk adder LSB-first, one chunk per clock, with a registered carry chain.
- Presents sum/cout on a valid/ready output handshake.
- Sits between the vector-driven stimulus/response path and the adder datapath; replaces a full-width combinational adder where timing or area forbids one.

---
 rtl/adder_seq_pkg.sv | 20 ++
 rtl/adder_chunk.sv | 14 +
 rtl/adder_seq_ctrl.sv | 115 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// Defaults describe a 65-bit add stepped over a 16-bit slice.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  localparam int DEF_WIDTH  = 65;
  localparam int DEF_CHUNK  = 16;
  localparam int DEF_NCHUNK = calc_nchunk(DEF_WIDTH, DEF_CHUNK);
  localparam int PADW       = DEF_NCHUNK * DEF_CHUNK;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit slice adder with carry in/out; zero latency, no flow control.
module adder_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequences a WIDTH-bit add over one CHUNK-bit slice, LSB chunk first; result valid NCHUNK clocks
// after accept. One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           state_q;
  logic [PAD_W-1:0] a_q, b_q, acc_q, acc_d;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, cout_d;
  logic             out_valid_q, busy_q;

  logic [CHUNK-1:0] slice_x, slice_y, slice_s;
  logic             slice_co;

  always_comb begin
    slice_x = a_q[int'(idx_q)*CHUNK +: CHUNK];
    slice_y = b_q[int'(idx_q)*CHUNK +: CHUNK];
    acc_d   = acc_q;
    acc_d[int'(idx_q)*CHUNK +: CHUNK] = slice_s;
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // With a partial top chunk, cout is padded bit WIDTH; every bit above it is provably zero.
  if (PAD_W == WIDTH) begin : g_cout_exact
    assign cout_d = slice_co;
  end else begin : g_cout_padded
    assign cout_d = |acc_d[PAD_W-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= PAD_W'(a);
            b_q     <= PAD_W'(b);
            carry_q <= cin;
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= slice_co;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            sum_q       <= acc_d[WIDTH-1:0];
            cout_q      <= cout_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized and directed bench for adder_seq_ctrl against a cycle-count/arithmetic reference model.
module tb_adder_seq_ctrl;

  localparam int W   = 65;
  localparam int NCH = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks = 0;
  int failures = 0;

  adder_seq_ctrl #(.WIDTH(65), .CHUNK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [65:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
    return {1'b0, x} + {1'b0, y} + 66'(c);
  endfunction

  function automatic logic [W-1:0] rnd65();
    logic [95:0] t;
    int sel;
    sel = $urandom_range(9, 0);
    t = {$urandom(), $urandom(), $urandom()};
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    if (sel == 2) return {1'b1, 64'h0};
    return t[W-1:0];
  endfunction

  // Reference: an operation is in flight from accept until the output handshake;
  // its result appears NCH cycles after accept and stays until the next result.
  logic        m_active;
  int          m_age;
  logic [65:0] m_pend, m_show;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_pend   <= '0;
      m_show   <= '0;
    end else if (m_active && m_age == NCH && out_ready) begin
      m_active <= 1'b0;
    end else if (m_active) begin
      if (m_age < NCH) m_age <= m_age + 1;
      if (m_age == NCH - 1) m_show <= m_pend;
    end else if (in_valid) begin
      m_active <= 1'b1;
      m_age    <= 0;
      m_pend   <= ref_add(a, b, cin);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 66'(out_valid), 66'(m_active && m_age == NCH));
    chk("in_ready",  66'(in_ready),  66'(!m_active));
    chk("busy",      66'(busy),      66'(m_active));
    chk("sum",       66'(sum),       66'(m_show[W-1:0]));
    chk("cout",      66'(cout),      66'(m_show[W]));
  end

  logic         noise = 1'b0;
  logic         nxt_valid = 1'b0;
  logic [W-1:0] nxt_a = '0, nxt_b = '0;
  logic         nxt_cin = 1'b0;

  // Entered and left at posedge+1.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input logic [W-1:0] es, input logic ec, input int hold);
    int lat;
    in_valid = 1'b1; a = ta; b = tb; cin = tc; out_ready = 1'b0;
    lat = 0;
    while (!in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("accept_wait", 66'(in_ready), 66'(1));
    @(posedge clk); #1;
    in_valid = noise ? 1'($urandom) : 1'b0;
    a = rnd65(); b = rnd65(); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (noise) begin in_valid = 1'($urandom); a = rnd65(); b = rnd65(); end
    end
    chk("latency", 66'(lat), 66'(NCH));
    chk("lit_sum", 66'(sum), 66'(es));
    chk("lit_cout", 66'(cout), 66'(ec));
    if (nxt_valid) begin in_valid = 1'b1; a = nxt_a; b = nxt_b; cin = nxt_cin; end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 66'(out_valid), 66'(1));
      chk("hold_sum", 66'(sum), 66'(es));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (!nxt_valid) in_valid = 1'b0;
    chk("ready_after_done", 66'(in_ready), 66'(1));
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 66'(in_ready), 66'(1));
    chk("rst_out_valid", 66'(out_valid), 66'(0));
    chk("rst_sum", 66'({cout, sum}), 66'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op('0, '0, 1'b0, '0, 1'b0, 0);
    run_op({W{1'b1}}, '0, 1'b1, '0, 1'b1, 0);
    run_op({1'b1, 64'h0}, {1'b1, 64'h0}, 1'b0, '0, 1'b1, 0);
    run_op(65'hFFFF, 65'h1, 1'b0, 65'h10000, 1'b0, 1);

    // Stall in DONE while the next pair is already offered.
    nxt_valid = 1'b1; nxt_a = 65'h1234; nxt_b = 65'h4321; nxt_cin = 1'b1;
    run_op(65'h10, 65'h20, 1'b0, 65'h30, 1'b0, 3);
    nxt_valid = 1'b0;
    run_op(65'h1234, 65'h4321, 1'b1, 65'h5556, 1'b0, 0);

    // Abort mid-RUN after chunk 2.
    in_valid = 1'b1; a = {W{1'b1}}; b = {W{1'b1}}; cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 66'(out_valid), 66'(0));
    chk("abort_busy", 66'(busy), 66'(0));
    chk("abort_sum", 66'(sum), 66'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(65'd5, 65'd7, 1'b1, 65'd13, 1'b0, 0);

    noise = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [65:0]  r;
      ra = rnd65(); rb = rnd65(); rc = 1'($urandom);
      r = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, r[W-1:0], r[W], $urandom_range(3, 0));
      if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
    end
    noise = 1'b0;

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
